sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Command arbiter and sequencer between SDRAM command sources and the physical SDRAM pins.
- Four sources share the pins: power-up init, auto-refresh, burst write and burst read.
- Until init completes, the init source owns the pins. After that, a state machine grants pin ownership to one requester at a time (refresh > write > read) and muxes that requester's command, bank and address onto the pins.

Parameters:
- ADDR_W, 13, SDRAM address width
- BANK_W, 2, bank address width
- DATA_W, 16, DQ width

Ports:
- arb_clk  in  1  system clock, 100 MHz
- arb_rst  in  1  asynchronous active-high reset
- init_end  in  1  init complete, level
- init_cmd  in  4  init command {CS#,RAS#,CAS#,WE#}
- init_bank  in  BANK_W  init bank
- init_addr  in  ADDR_W  init address
- aref_req  in  1  refresh request, level, held until granted
- aref_end  in  1  refresh done, 1-cycle pulse
- aref_cmd  in  4  refresh command
- aref_bank  in  BANK_W  refresh bank
- aref_addr  in  ADDR_W  refresh address
- aref_en  out  1  refresh grant
- wr_req  in  1  write request, level
- wr_end  in  1  write done, pulse
- wr_cmd  in  4  write command
- wr_bank  in  BANK_W  write bank
- wr_addr  in  ADDR_W  write address
- wr_sdram_en  in  1  write module driving DQ
- wr_sdram_data  in  DATA_W  write data
- wr_en  out  1  write grant
- rd_req  in  1  read request, level
- rd_end  in  1  read done, pulse
- rd_cmd  in  4  read command
- rd_bank  in  BANK_W  read bank
- rd_addr  in  ADDR_W  read address
- rd_en  out  1  read grant
- sdram_cke  out  1  clock enable
- sdram_cs_n  out  1  chip select
- sdram_ras_n  out  1  RAS#
- sdram_cas_n  out  1  CAS#
- sdram_we_n  out  1  WE#
- sdram_ba  out  BANK_W  bank
- sdram_addr  out  ADDR_W  address
- sdram_dq_out  out  DATA_W  DQ drive value
- sdram_dq_oe  out  1  DQ output enable

Behaviour:
- Clock and reset: one clock arb_clk; reset arb_rst is asynchronous and active-high.
- State register: clocked by arb_clk; arb_rst forces state IDLE. Encodings: IDLE=000, ARBIT=001, AREF=011, WRITE=010, READ=110. Any other value goes to IDLE on the next cycle.
- Transitions:
  - IDLE -> ARBIT on the cycle after init_end=1 is sampled.
  - ARBIT -> AREF if aref_req=1; else WRITE if wr_req=1; else READ if rd_req=1; else stay in ARBIT.
  - AREF -> ARBIT when aref_end=1. WRITE -> ARBIT when wr_end=1. READ -> ARBIT when rd_end=1.
- No back-to-back grants: every grant returns through ARBIT, giving at least 1 NOP cycle between owners.
- init_end falling after IDLE is ignored; the arbiter does not return to IDLE except on reset.
- Requests asserted while another owner is active are not latched by the arbiter. The requester holds req high; it is evaluated in the next ARBIT cycle.
- Grant outputs are combinational decodes of the state: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ). All three are 0 during reset.
- A req and its own end in the same cycle: the end takes precedence and the block goes to ARBIT.
- Command mux is combinational from state:
  - IDLE: init_cmd/bank/addr.
  - AREF: aref_*.
  - WRITE: wr_*.
  - READ: rd_*.
  - ARBIT and reset: NOP 4'b0111, ba all-ones, addr all-ones.
- {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n} = selected cmd.
- sdram_cke is constant 1, including during reset.
- sdram_dq_oe = wr_sdram_en when state==WRITE, else 0. sdram_dq_out = wr_sdram_data; its value is don't-care when oe=0.
- Reset mid-operation: grant drops and the pins show NOP in the same cycle, asynchronously.
- Latency:
  - req sampled in ARBIT -> grant 1 cycle later.
  - end pulse -> grant low 1 cycle later; the pins are NOP that cycle.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined:
  - Write and read share round-robin priority. A 1-bit last_owner register resets to READ and updates on entry to WRITE or READ.
  - With wr_req=rd_req=1 and aref_req=0 in ARBIT, the requester that was not last_owner is granted.
  - Refresh keeps absolute priority.
- Undefined: fixed priority, write over read; no last_owner register.

Test Plan:
- Reset, init_cmd=4'b0010, init_end=0 -> pins follow init_cmd; grants 0; cke=1. Then init_end=1 -> next cycle state ARBIT, pins NOP 0111, ba=2'b11, addr=13'h1fff.
- In ARBIT, aref_req=wr_req=rd_req=1 -> aref_en=1 next cycle, pins = aref_cmd 0001. aref_end pulse -> 1 NOP cycle, then wr_en=1.
- WRITE with wr_sdram_en=1, data 16'hA5A5 -> dq_oe=1, dq_out=16'hA5A5. wr_end -> dq_oe=0 next cycle.
- aref_req rises during READ -> rd_en held until rd_end; ARBIT 1 cycle; then aref_en=1.
- arb_rst asserted mid-WRITE -> wr_en=0 and pins NOP immediately. After release, state IDLE until init_end is seen.
- SDRAM_ARB_RR_EN defined, wr_req=rd_req=1 continuous, each grant ended after 4 cycles -> grants alternate WRITE, READ, WRITE, ... Undefined -> WRITE every time.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundle of every non-clock signal around the SDRAM
// command arbiter.
//   init_*  : power-up init source (init_end level, cmd/bank/addr)
//   aref_*  : auto-refresh source (req level, end pulse, cmd/bank/addr, en grant)
//   wr_*    : burst-write source (req, end, cmd/bank/addr, DQ drive, en grant)
//   rd_*    : burst-read source (req, end, cmd/bank/addr, en grant)
//   sdram_* : physical pin side (cke, cs/ras/cas/we, ba, addr, dq_out, dq_oe)
// modport slave  : the arbiter's view
// modport master : the command sources / pin side view
interface sdram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2,
  parameter int DATA_W = 16
);
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BANK_W-1:0] init_bank;
  logic [ADDR_W-1:0] init_addr;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [BANK_W-1:0] aref_bank;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic              wr_en;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;

  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BANK_W-1:0] sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  modport slave (
    input  init_end, init_cmd, init_bank, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );

  modport master (
    output init_end, init_cmd, init_bank, init_addr,
    output aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: hands the SDRAM pins to one command source at a time.
// The init source owns the pins until init_end; afterwards refresh > write >
// read, each grant returning through ARBIT (one NOP cycle between owners).
// Ports:
//   arb_clk : system clock
//   arb_rst : asynchronous active-high reset (pins show NOP while asserted)
//   bus     : sdram_arbiter_if.slave, all source and pin signals
// Optional macro SDRAM_ARB_RR_EN: write and read alternate when both request
// (refresh still wins); without it write always beats read.
//
// state | meaning
// IDLE  | init source owns the pins, waiting for init_end
// ARBIT | NOP on the pins, choosing the next owner
// AREF  | refresh source owns the pins
// WRITE | write source owns the pins and may drive DQ
// READ  | read source owns the pins
module sdram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2,
  parameter int DATA_W = 16
) (
  input logic            arb_clk,
  input logic            arb_rst,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ARBIT = 3'b001,
    AREF  = 3'b011,
    WRITE = 3'b010,
    READ  = 3'b110
  } state_t;

  localparam logic [3:0]        CMD_NOP  = 4'b0111;
  localparam logic [BANK_W-1:0] BA_NOP   = '1;
  localparam logic [ADDR_W-1:0] ADDR_NOP = '1;

  state_t state;
  logic   pick_rd;

`ifdef SDRAM_ARB_RR_EN
  logic last_rd;  // 1: read was the most recent data owner
  // Read wins a write/read tie only when write went last.
  assign pick_rd = bus.rd_req & (~bus.wr_req | ~last_rd);
`else
  assign pick_rd = bus.rd_req & ~bus.wr_req;
`endif

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state <= IDLE;
`ifdef SDRAM_ARB_RR_EN
      last_rd <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE:  if (bus.init_end) state <= ARBIT;
        ARBIT: begin
          if (bus.aref_req) begin
            state <= AREF;
          end else if (pick_rd) begin
            state <= READ;
`ifdef SDRAM_ARB_RR_EN
            last_rd <= 1'b1;
`endif
          end else if (bus.wr_req) begin
            state <= WRITE;
`ifdef SDRAM_ARB_RR_EN
            last_rd <= 1'b0;
`endif
          end
        end
        AREF:  if (bus.aref_end) state <= ARBIT;
        WRITE: if (bus.wr_end)   state <= ARBIT;
        READ:  if (bus.rd_end)   state <= ARBIT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.aref_en = (state == AREF);
  assign bus.wr_en   = (state == WRITE);
  assign bus.rd_en   = (state == READ);

  logic [3:0]        cmd_sel;
  logic [BANK_W-1:0] ba_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] dq_sel;

  // arb_rst is in the mux so the pins fall to NOP combinationally on reset,
  // not merely because the state register is forced back to IDLE (which
  // would otherwise expose the init source).
  always_comb begin
    cmd_sel  = CMD_NOP;
    ba_sel   = BA_NOP;
    addr_sel = ADDR_NOP;
    if (!arb_rst) begin
      case (state)
        IDLE:  begin cmd_sel = bus.init_cmd; ba_sel = bus.init_bank; addr_sel = bus.init_addr; end
        AREF:  begin cmd_sel = bus.aref_cmd; ba_sel = bus.aref_bank; addr_sel = bus.aref_addr; end
        WRITE: begin cmd_sel = bus.wr_cmd;   ba_sel = bus.wr_bank;   addr_sel = bus.wr_addr;   end
        READ:  begin cmd_sel = bus.rd_cmd;   ba_sel = bus.rd_bank;   addr_sel = bus.rd_addr;   end
        default: ;
      endcase
    end
  end

  assign dq_sel = bus.wr_sdram_data;

  assign bus.sdram_cke = 1'b1;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd_sel;
  assign bus.sdram_ba     = ba_sel;
  assign bus.sdram_addr   = addr_sel;
  assign bus.sdram_dq_out = dq_sel;
  assign bus.sdram_dq_oe  = (state == WRITE) & bus.wr_sdram_en;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus for sdram_arbiter; each cycle's expected
// pin/grant picture is queued by the stimulus and checked by a separate
// negedge monitor.
module tb_sdram_arbiter;

  logic arb_clk;
  logic arb_rst;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  sdram_arbiter_if #(.ADDR_W(13), .BANK_W(2), .DATA_W(16)) bus ();

  sdram_arbiter #(.ADDR_W(13), .BANK_W(2), .DATA_W(16)) dut (
    .arb_clk (arb_clk),
    .arb_rst (arb_rst),
    .bus     (bus)
  );

  initial begin
    arb_clk = 1'b0;
    forever #5 arb_clk = ~arb_clk;
  end

  always @(posedge arb_clk) cyc++;

  typedef enum int {O_NOP, O_INIT, O_AREF, O_WR, O_RD} owner_t;

  typedef struct {
    string       name;
    int          tag;
    logic [39:0] vec;
  } exp_t;

  exp_t q[$];

  // Source command constants driven for the whole run.
  localparam logic [3:0]  INIT_CMD = 4'b0010, AREF_CMD = 4'b0001, WR_CMD = 4'b0100, RD_CMD = 4'b0101;
  localparam logic [1:0]  INIT_BA  = 2'b01,  AREF_BA  = 2'b10,  WR_BA  = 2'b00,  RD_BA  = 2'b11;
  localparam logic [12:0] INIT_AD  = 13'h0400, AREF_AD = 13'h0aaa, WR_AD = 13'h0123, RD_AD = 13'h0456;
  localparam logic [15:0] WDATA    = 16'hA5A5;

  // {aref_en,wr_en,rd_en,cke,cmd,ba,addr,oe,dq-if-oe}
  function automatic logic [39:0] expect_vec(owner_t o, logic oe);
    logic [2:0]  g;
    logic [3:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    g = 3'b000; c = 4'b0111; b = 2'b11; a = 13'h1fff;
    case (o)
      O_INIT: begin c = INIT_CMD; b = INIT_BA; a = INIT_AD; end
      O_AREF: begin g = 3'b100; c = AREF_CMD; b = AREF_BA; a = AREF_AD; end
      O_WR:   begin g = 3'b010; c = WR_CMD;   b = WR_BA;   a = WR_AD;   end
      O_RD:   begin g = 3'b001; c = RD_CMD;   b = RD_BA;   a = RD_AD;   end
      default: ;
    endcase
    return {g, 1'b1, c, b, a, oe, (oe ? WDATA : 16'h0000)};
  endfunction

  task automatic adv();
    @(posedge arb_clk);
    #1;
  endtask

  task automatic expect_now(string name, owner_t o, logic oe);
    exp_t e;
    e.name = name;
    e.tag  = cyc;
    e.vec  = expect_vec(o, oe);
    q.push_back(e);
  endtask

  // Monitor: pops every expectation tagged with the current cycle.
  always @(negedge arb_clk) begin
    logic [39:0] got;
    exp_t e;
    got = {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cke,
           bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
           bus.sdram_ba, bus.sdram_addr, bus.sdram_dq_oe,
           (bus.sdram_dq_oe ? bus.sdram_dq_out : 16'h0000)};
    while (q.size() > 0 && q[0].tag <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.tag != cyc)
        $display("FAIL %s stale expectation tag=%0d at cyc=%0d", e.name, e.tag, cyc);
      else if (got !== e.vec)
        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, got, e.vec);
      else
        passed++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "timeout");
  end

  initial begin
    owner_t ow;
    arb_rst = 1'b1;
    bus.init_end = 0; bus.init_cmd = INIT_CMD; bus.init_bank = INIT_BA; bus.init_addr = INIT_AD;
    bus.aref_req = 0; bus.aref_end = 0; bus.aref_cmd = AREF_CMD; bus.aref_bank = AREF_BA; bus.aref_addr = AREF_AD;
    bus.wr_req = 0; bus.wr_end = 0; bus.wr_cmd = WR_CMD; bus.wr_bank = WR_BA; bus.wr_addr = WR_AD;
    bus.wr_sdram_en = 0; bus.wr_sdram_data = WDATA;
    bus.rd_req = 0; bus.rd_end = 0; bus.rd_cmd = RD_CMD; bus.rd_bank = RD_BA; bus.rd_addr = RD_AD;

    adv(); expect_now("reset_nop", O_NOP, 0);
    adv(); arb_rst = 0; expect_now("init_pins", O_INIT, 0);
    adv(); expect_now("init_wait", O_INIT, 0);
    adv(); bus.init_end = 1; expect_now("init_end_seen", O_INIT, 0);
    adv(); bus.init_end = 0; expect_now("arbit_nop", O_NOP, 0);
    adv(); expect_now("init_fall_ignored", O_NOP, 0);
    bus.aref_req = 1; bus.wr_req = 1; bus.rd_req = 1;
    adv(); bus.aref_req = 0; expect_now("aref_priority", O_AREF, 0);
    adv(); bus.aref_end = 1; expect_now("aref_hold", O_AREF, 0);
    adv(); bus.aref_end = 0; expect_now("aref_end_nop", O_NOP, 0);
    adv(); bus.wr_sdram_en = 1; expect_now("wr_grant_dq", O_WR, 1);
    adv(); bus.wr_end = 1; expect_now("wr_end_same_req", O_WR, 1);
    adv(); bus.wr_end = 0; bus.wr_req = 0; expect_now("wr_end_oe_low", O_NOP, 0);
    adv(); bus.aref_req = 1; expect_now("rd_grant", O_RD, 0);
    adv(); expect_now("rd_not_preempted", O_RD, 0);
    adv(); bus.rd_end = 1; bus.rd_req = 0; expect_now("rd_end_cycle", O_RD, 0);
    adv(); bus.rd_end = 0; expect_now("rd_end_nop", O_NOP, 0);
    adv(); bus.aref_req = 0; bus.aref_end = 1; expect_now("aref_after_rd", O_AREF, 0);
    adv(); bus.aref_end = 0; bus.wr_req = 1; expect_now("aref_end_nop2", O_NOP, 0);
    adv(); expect_now("wr_only_grant", O_WR, 1);
    adv(); arb_rst = 1; expect_now("rst_mid_write", O_NOP, 0);
    adv(); arb_rst = 0; expect_now("post_rst_idle", O_INIT, 0);
    adv(); expect_now("idle_no_init_end", O_INIT, 0);
    bus.init_end = 1;
    adv(); bus.rd_req = 1; expect_now("rearbit_nop", O_NOP, 0);

    // wr_req and rd_req held high; each grant ended after 4 cycles.
    for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_RR_EN
      ow = (k % 2 == 0) ? O_WR : O_RD;
`else
      ow = O_WR;
`endif
      for (int c = 0; c < 4; c++) begin
        adv();
        if (c == 3) begin
          if (ow == O_WR) bus.wr_end = 1;
          else            bus.rd_end = 1;
        end
        expect_now($sformatf("rr_grant%0d_c%0d", k, c), ow, (ow == O_WR));
      end
      adv(); bus.wr_end = 0; bus.rd_end = 0;
      expect_now($sformatf("rr_gap%0d", k), O_NOP, 0);
    end

    @(negedge arb_clk);
    #1;
    total++;
    if (q.size() != 0)
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
